fifo_wr_gate_tmr: RTL and testbench

Sits directly downstream of the FIFO reset sequencer. It consumes that sequencer's DONE flag and gates ADC sample writes into the readout FIFO, so writes start only on a frame boundary after the FIFO reset completes. Whole frames are skipped when the FIFO is almost full. On a hard overflow it latches an error and, on command, requests a re-run of the reset sequence. State, counters and registered outputs are triplicated, with majority voting as in the other TMR FSMs.

---
 rtl/fifo_wr_gate_tmr_if.sv | 33 +++
 rtl/fifo_wr_gate_tmr.sv | 195 +++++++++++++++++++
 tb/tb_fifo_wr_gate_tmr.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_gate_tmr_if.sv
// Sample stream in / readout FIFO write port of the frame-aligned write gate.
// The gate drives the FIFO write side; the environment (ADC + FIFO) is the slave.
interface fifo_wr_gate_tmr_if #(
    parameter int DW = 12
);
    logic [DW-1:0] DIN;
    logic          DATA_VALID;
    logic          FRAME_START;
    logic          FIFO_FULL;
    logic          FIFO_AFULL;
    logic          WR_EN;
    logic [DW-1:0] DOUT;

    modport master (
        input  DIN,
        input  DATA_VALID,
        input  FRAME_START,
        input  FIFO_FULL,
        input  FIFO_AFULL,
        output WR_EN,
        output DOUT
    );

    modport slave (
        output DIN,
        output DATA_VALID,
        output FRAME_START,
        output FIFO_FULL,
        output FIFO_AFULL,
        input  WR_EN,
        input  DOUT
    );
endinterface

// File: rtl/fifo_wr_gate_tmr.sv
// Frame-aligned FIFO write gate with triplicated state, counters and outputs.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_RST   | FIFO reset sequencer not done; nothing is written
// WAIT_FRAME | FIFO clean; waiting for a frame start with room in FIFO
// WRITE      | passing samples of the current frame into the FIFO
// OVERFLOW   | sample hit a full FIFO; error latched until RECOVER
// REQ_RST    | asking the sequencer to re-run; leave when DONE drops
//
// Every register exists three times. Next values are computed once from the
// bitwise majority of the copies and written back to all three, so a single
// upset is masked at the outputs and scrubbed at the next clock.
module fifo_wr_gate_tmr #(
    parameter int DW   = 12,
    parameter int CNTW = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RST_DONE,
    input  logic                   RECOVER,
    fifo_wr_gate_tmr_if.master     bus,
    output logic                   ARMED,
    output logic                   OVFL,
    output logic                   RESET_REQ,
    output logic [CNTW-1:0]        OVFL_CNT,
    output logic [CNTW-1:0]        FRAME_CNT
);

    typedef enum logic [2:0] {
        WAIT_RST   = 3'd0,
        WAIT_FRAME = 3'd1,
        WRITE      = 3'd2,
        OVERFLOW   = 3'd3,
        REQ_RST    = 3'd4
    } state_t;

    logic [2:0]      st_a, st_b, st_c, st_v;
    logic [CNTW-1:0] oc_a, oc_b, oc_c, oc_v;
    logic [CNTW-1:0] fc_a, fc_b, fc_c, fc_v;
    logic            wr_a, wr_b, wr_c;
    logic [DW-1:0]   do_a, do_b, do_c, do_v;
    logic            arm_a, arm_b, arm_c;
    logic            ovf_a, ovf_b, ovf_c;
    logic            req_a, req_b, req_c;

    state_t          nxt;
    logic [CNTW-1:0] oc_n, fc_n;
    logic            wr_n, arm_n, ovf_n, req_n;
    logic [DW-1:0]   do_n;

    logic            dv, fs, full, afull;
    logic [DW-1:0]   din;

    assign dv    = bus.DATA_VALID;
    assign fs    = bus.FRAME_START;
    assign full  = bus.FIFO_FULL;
    assign afull = bus.FIFO_AFULL;
    assign din   = bus.DIN;

    assign st_v = (st_a & st_b) | (st_a & st_c) | (st_b & st_c);
    assign oc_v = (oc_a & oc_b) | (oc_a & oc_c) | (oc_b & oc_c);
    assign fc_v = (fc_a & fc_b) | (fc_a & fc_c) | (fc_b & fc_c);
    assign do_v = (do_a & do_b) | (do_a & do_c) | (do_b & do_c);

    assign bus.WR_EN = (wr_a & wr_b) | (wr_a & wr_c) | (wr_b & wr_c);
    assign bus.DOUT  = do_v;
    assign ARMED     = (arm_a & arm_b) | (arm_a & arm_c) | (arm_b & arm_c);
    assign OVFL      = (ovf_a & ovf_b) | (ovf_a & ovf_c) | (ovf_b & ovf_c);
    assign RESET_REQ = (req_a & req_b) | (req_a & req_c) | (req_b & req_c);
    assign OVFL_CNT  = oc_v;
    assign FRAME_CNT = fc_v;

    // Next state, counters and registered outputs from the voted copies.
    always_comb begin
        nxt  = WAIT_RST;
        oc_n = oc_v;
        fc_n = fc_v;
        wr_n = 1'b0;
        do_n = do_v;
        case (st_v)
            WAIT_RST: begin
                nxt = RST_DONE ? WAIT_FRAME : WAIT_RST;
            end
            WAIT_FRAME: begin
                if (!RST_DONE) begin
                    nxt = WAIT_RST;
                end else if (dv && fs && !afull && !full) begin
                    nxt  = WRITE;
                    wr_n = 1'b1;
                    do_n = din;
                    fc_n = fc_v + 1'b1;
                end else begin
                    nxt = WAIT_FRAME;
                end
            end
            WRITE: begin
                nxt = WRITE;
                if (!RST_DONE) begin
                    nxt = WAIT_RST;
                end else if (dv && full) begin
                    // Overflow beats a coincident frame start.
                    nxt = OVERFLOW;
                    if (oc_v != {CNTW{1'b1}}) begin
                        oc_n = oc_v + 1'b1;
                    end
                end else if (dv && fs && afull) begin
                    // Skip the whole frame rather than writing a partial one.
                    nxt = WAIT_FRAME;
                end else if (dv) begin
                    wr_n = 1'b1;
                    do_n = din;
                    if (fs) begin
                        fc_n = fc_v + 1'b1;
                    end
                end
            end
            OVERFLOW: begin
                // RECOVER wins over a simultaneous loss of RST_DONE.
                if (RECOVER) begin
                    nxt = REQ_RST;
                end else if (!RST_DONE) begin
                    nxt = WAIT_RST;
                end else begin
                    nxt = OVERFLOW;
                end
            end
            REQ_RST: begin
                nxt = RST_DONE ? REQ_RST : WAIT_RST;
            end
            default: begin
                nxt = WAIT_RST;
            end
        endcase
        arm_n = (nxt == WAIT_FRAME) || (nxt == WRITE);
        ovf_n = (nxt == OVERFLOW);
        req_n = (nxt == REQ_RST);
    end

    // All three copies are rewritten each cycle from the voted next values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            st_a  <= WAIT_RST;
            st_b  <= WAIT_RST;
            st_c  <= WAIT_RST;
            oc_a  <= '0;
            oc_b  <= '0;
            oc_c  <= '0;
            fc_a  <= '0;
            fc_b  <= '0;
            fc_c  <= '0;
            wr_a  <= 1'b0;
            wr_b  <= 1'b0;
            wr_c  <= 1'b0;
            do_a  <= '0;
            do_b  <= '0;
            do_c  <= '0;
            arm_a <= 1'b0;
            arm_b <= 1'b0;
            arm_c <= 1'b0;
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
            ovf_c <= 1'b0;
            req_a <= 1'b0;
            req_b <= 1'b0;
            req_c <= 1'b0;
        end else begin
            st_a  <= nxt;
            st_b  <= nxt;
            st_c  <= nxt;
            oc_a  <= oc_n;
            oc_b  <= oc_n;
            oc_c  <= oc_n;
            fc_a  <= fc_n;
            fc_b  <= fc_n;
            fc_c  <= fc_n;
            wr_a  <= wr_n;
            wr_b  <= wr_n;
            wr_c  <= wr_n;
            do_a  <= do_n;
            do_b  <= do_n;
            do_c  <= do_n;
            arm_a <= arm_n;
            arm_b <= arm_n;
            arm_c <= arm_n;
            ovf_a <= ovf_n;
            ovf_b <= ovf_n;
            ovf_c <= ovf_n;
            req_a <= req_n;
            req_b <= req_n;
            req_c <= req_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_gate_tmr.sv
// Directed bench for the frame-aligned TMR FIFO write gate.
module tb_fifo_wr_gate_tmr;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RST_DONE;
    logic       RECOVER;
    logic       ARMED;
    logic       OVFL;
    logic       RESET_REQ;
    logic [7:0] OVFL_CNT;
    logic [7:0] FRAME_CNT;

    int checks   = 0;
    int failures = 0;
    int nwr;

    fifo_wr_gate_tmr_if #(.DW(12)) bus ();

    fifo_wr_gate_tmr #(.DW(12), .CNTW(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RST_DONE  (RST_DONE),
        .RECOVER   (RECOVER),
        .bus       (bus),
        .ARMED     (ARMED),
        .OVFL      (OVFL),
        .RESET_REQ (RESET_REQ),
        .OVFL_CNT  (OVFL_CNT),
        .FRAME_CNT (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic wr, input logic [11:0] dout,
                           input logic arm, input logic ovf, input logic req,
                           input logic [7:0] oc, input logic [7:0] fc);
        chk({tag, ".wr_en"},     32'(bus.WR_EN), 32'(wr));
        chk({tag, ".dout"},      32'(bus.DOUT),  32'(dout));
        chk({tag, ".armed"},     32'(ARMED),     32'(arm));
        chk({tag, ".ovfl"},      32'(OVFL),      32'(ovf));
        chk({tag, ".reset_req"}, 32'(RESET_REQ), 32'(req));
        chk({tag, ".ovfl_cnt"},  32'(OVFL_CNT),  32'(oc));
        chk({tag, ".frame_cnt"}, 32'(FRAME_CNT), 32'(fc));
    endtask

    task automatic drive(input logic dv, input logic fs, input logic [11:0] din,
                         input logic afull, input logic full);
        bus.DATA_VALID  = dv;
        bus.FRAME_START = fs;
        bus.DIN         = din;
        bus.FIFO_AFULL  = afull;
        bus.FIFO_FULL   = full;
    endtask

    // Outputs are sampled 1 ns after the edge; new inputs are applied then.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST      = 1'b1;
        RST_DONE = 1'b0;
        RECOVER  = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

        // Startup
        repeat (3) tick();
        RST = 1'b0;
        chk_all("reset", 0, 12'h000, 0, 0, 0, 8'd0, 8'd0);
        repeat (6) tick();
        chk("armed_before_done", 32'(ARMED), 32'd0);
        RST_DONE = 1'b1;
        tick();
        chk_all("armed", 0, 12'h000, 1, 0, 0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 12'h0AA, 1'b0, 1'b0);
        repeat (3) tick();
        chk_all("no_frame_yet", 0, 12'h000, 1, 0, 0, 8'd0, 8'd0);
        drive(1'b1, 1'b1, 12'h123, 1'b0, 1'b0);
        tick();
        chk_all("first_write", 1, 12'h123, 1, 0, 0, 8'd0, 8'd1);
        drive(1'b1, 1'b0, 12'h124, 1'b0, 1'b0);
        tick();
        chk_all("write_124", 1, 12'h124, 1, 0, 0, 8'd0, 8'd1);
        drive(1'b1, 1'b0, 12'h125, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 12'hFFF, 1'b0, 1'b0);
        tick();
        chk_all("gap_holds_dout", 0, 12'h125, 1, 0, 0, 8'd0, 8'd1);
        drive(1'b1, 1'b1, 12'h200, 1'b0, 1'b0);
        tick();
        chk_all("frame2", 1, 12'h200, 1, 0, 0, 8'd0, 8'd2);

        // Almost full at a frame start skips the whole 8-sample frame
        drive(1'b1, 1'b1, 12'h300, 1'b1, 1'b0);
        tick();
        chk_all("afull_skip", 0, 12'h200, 1, 0, 0, 8'd0, 8'd2);
        nwr = 0;
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 1'b0, 12'(12'h300 + i), 1'b0, 1'b0);
            tick();
            if (bus.WR_EN) nwr++;
        end
        chk("skipped_frame_writes", 32'(nwr), 32'd0);
        drive(1'b1, 1'b1, 12'h400, 1'b0, 1'b0);
        tick();
        chk_all("frame3", 1, 12'h400, 1, 0, 0, 8'd0, 8'd3);
        drive(1'b1, 1'b0, 12'h401, 1'b1, 1'b0);
        tick();
        chk_all("afull_mid_frame", 1, 12'h401, 1, 0, 0, 8'd0, 8'd3);

        // Single-copy upsets in Write
        drive(1'b1, 1'b0, 12'h402, 1'b0, 1'b0);
        force dut.st_b = 3'd3;
        force dut.oc_a = 8'hFF;
        force dut.wr_c = 1'b0;
        #1;
        release dut.st_b;
        release dut.oc_a;
        release dut.wr_c;
        chk_all("seu_masked", 1, 12'h401, 1, 0, 0, 8'd0, 8'd3);
        tick();
        chk_all("seu_next", 1, 12'h402, 1, 0, 0, 8'd0, 8'd3);
        drive(1'b1, 1'b0, 12'h403, 1'b0, 1'b0);
        force dut.st_a = 3'd3;
        force dut.fc_c = 8'h00;
        #1;
        release dut.st_a;
        release dut.fc_c;
        tick();
        chk_all("seu_scrubbed", 1, 12'h403, 1, 0, 0, 8'd0, 8'd3);

        // Overflow beats frame start
        drive(1'b1, 1'b1, 12'h500, 1'b0, 1'b1);
        tick();
        chk_all("overflow", 0, 12'h403, 0, 1, 0, 8'd1, 8'd3);
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        tick();
        chk_all("overflow_stays", 0, 12'h403, 0, 1, 0, 8'd1, 8'd3);

        // 299 more overflow events; frame counter wraps along the way
        for (int i = 0; i < 299; i++) begin
            RST_DONE = 1'b0;
            drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
            tick();
            RST_DONE = 1'b1;
            tick();
            drive(1'b1, 1'b1, 12'h7A5, 1'b0, 1'b0);
            tick();
            drive(1'b1, 1'b0, 12'hBAD, 1'b0, 1'b1);
            tick();
            if (i == 252) chk("ovfl_cnt_254", 32'(OVFL_CNT), 32'd254);
        end
        chk_all("ovfl_saturated", 0, 12'h7A5, 0, 1, 0, 8'd255, 8'd46);

        // RECOVER wins over RST_DONE=0 in Overflow
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        RST_DONE = 1'b0;
        RECOVER  = 1'b1;
        tick();
        RECOVER = 1'b0;
        chk_all("recover_wins", 0, 12'h7A5, 0, 0, 1, 8'd255, 8'd46);
        tick();
        chk_all("req_released", 0, 12'h7A5, 0, 0, 0, 8'd255, 8'd46);
        RST_DONE = 1'b1;
        tick();
        drive(1'b1, 1'b1, 12'h555, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 12'h556, 1'b0, 1'b1);
        tick();
        chk_all("overflow2", 0, 12'h555, 0, 1, 0, 8'd255, 8'd47);

        // Recovery handshake: RESET_REQ held 4 cycles until DONE drops
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        RECOVER = 1'b1;
        tick();
        RECOVER = 1'b0;
        chk_all("req_start", 0, 12'h555, 0, 0, 1, 8'd255, 8'd47);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("req_hold", 32'(RESET_REQ), 32'd1);
        end
        RST_DONE = 1'b0;
        tick();
        chk_all("req_done", 0, 12'h555, 0, 0, 0, 8'd255, 8'd47);
        tick();
        chk("wait_rst_holds", 32'(ARMED), 32'd0);
        RST_DONE = 1'b1;
        tick();
        chk_all("rearmed", 0, 12'h555, 1, 0, 0, 8'd255, 8'd47);

        // Mid-frame start: first 5 samples are not written
        nwr = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 12'(12'h600 + i), 1'b0, 1'b0);
            tick();
            if (bus.WR_EN) nwr++;
        end
        chk("midframe_writes", 32'(nwr), 32'd0);
        drive(1'b1, 1'b1, 12'h605, 1'b0, 1'b0);
        tick();
        chk_all("midframe_first", 1, 12'h605, 1, 0, 0, 8'd255, 8'd48);

        // RECOVER in Write is ignored
        RECOVER = 1'b1;
        drive(1'b1, 1'b0, 12'h606, 1'b0, 1'b0);
        tick();
        RECOVER = 1'b0;
        chk_all("recover_ignored", 1, 12'h606, 1, 0, 0, 8'd255, 8'd48);

        // Reset mid-frame clears everything
        RST = 1'b1;
        drive(1'b1, 1'b0, 12'h607, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        chk_all("reset_mid_frame", 0, 12'h000, 0, 0, 0, 8'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
